// File: rtl/variable_node_if.sv
// Handshake bundle for the degree-3 variable node: input vector side and
// beta/decision output side.
interface variable_node_if;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] llr;
  logic [5:0] alpha1;
  logic [5:0] alpha2;
  logic [5:0] alpha3;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] beta1;
  logic [5:0] beta2;
  logic [5:0] beta3;
  logic [2:0] beta_sat;
  logic       decision;

  modport master (
    output in_valid, llr, alpha1, alpha2, alpha3, out_ready,
    input  in_ready, out_valid, beta1, beta2, beta3, beta_sat, decision
  );

  modport slave (
    input  in_valid, llr, alpha1, alpha2, alpha3, out_ready,
    output in_ready, out_valid, beta1, beta2, beta3, beta_sat, decision
  );
endinterface

// File: rtl/variable_node.sv
// Degree-3 min-sum variable node: two-stage valid/ready pipeline turning
// LLR + three alphas (2.4) into three saturated betas (3.3) and a hard bit.

// Per-edge extrinsic: (total - alpha) / 2 with floor, clipped to 6-bit 3.3.
module vn_beta (
  input  logic signed [8:0] total_i,
  input  logic [5:0]        alpha_i,
  output logic [5:0]        beta_o,
  output logic              sat_o
);
  logic signed [8:0] ext;
  logic signed [8:0] shr;

  assign ext    = total_i - $signed({{3{alpha_i[5]}}, alpha_i});
  assign shr    = ext >>> 1;
  // Fits in 6 bits only when the top four bits are all copies of the sign.
  assign sat_o  = ~((&shr[8:5]) | ~(|shr[8:5]));
  assign beta_o = sat_o ? (shr[8] ? 6'h20 : 6'h1F) : shr[5:0];
endmodule

module variable_node (
  input  logic           clk,
  input  logic           rst_n,
  variable_node_if.slave vn
);
  localparam int DEG = 3;

  logic [1:0]            vld_q;   // [0] = stage 1, [1] = stage 2
  logic                  en1, en2;

  logic signed [8:0]     total_d, total_q;
  logic [DEG-1:0][5:0]   alpha_d, alpha_q;
  logic [DEG-1:0][5:0]   beta_d, beta_q;
  logic [DEG-1:0]        sat_d, sat_q;
  logic                  dec_q;

  assign en2         = !vld_q[1] || vn.out_ready;
  assign en1         = !vld_q[0] || en2;
  assign vn.in_ready = en1;

  assign alpha_d = {vn.alpha3, vn.alpha2, vn.alpha1};
  assign total_d = $signed({{2{vn.llr[5]}}, vn.llr, 1'b0})
                 + $signed({{3{vn.alpha1[5]}}, vn.alpha1})
                 + $signed({{3{vn.alpha2[5]}}, vn.alpha2})
                 + $signed({{3{vn.alpha3[5]}}, vn.alpha3});

  for (genvar g = 0; g < DEG; g++) begin : g_edge
    vn_beta u_beta (
      .total_i (total_q),
      .alpha_i (alpha_q[g]),
      .beta_o  (beta_d[g]),
      .sat_o   (sat_d[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q   <= '0;
      total_q <= '0;
      alpha_q <= '0;
      beta_q  <= '0;
      sat_q   <= '0;
      dec_q   <= 1'b0;
    end else begin
      if (en1) begin
        vld_q[0] <= vn.in_valid;
        total_q  <= total_d;
        alpha_q  <= alpha_d;
      end
      if (en2) begin
        vld_q[1] <= vld_q[0];
        beta_q   <= beta_d;
        sat_q    <= sat_d;
        dec_q    <= total_q[8];
      end
    end
  end

  assign vn.out_valid = vld_q[1];
  assign vn.beta1     = beta_q[0];
  assign vn.beta2     = beta_q[1];
  assign vn.beta3     = beta_q[2];
  assign vn.beta_sat  = sat_q;
  assign vn.decision  = dec_q;
endmodule

// File: tb/tb_variable_node.sv
// Bench for variable_node: directed vectors with literal expectations plus an
// arithmetic/queue model compared against the outputs every cycle.
module tb_variable_node;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  variable_node_if bus ();
  variable_node dut (.clk(clk), .rst_n(rst_n), .vn(bus));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [17:0] betas;   // {beta1, beta2, beta3}
    logic [2:0]  sat;
    logic        dec;
    int          age;
  } ent_t;

  ent_t q[$];

  function automatic ent_t model(input logic [5:0] l, input logic [5:0] a1,
                                 input logic [5:0] a2, input logic [5:0] a3);
    ent_t r;
    int   al[3];
    int   li, t, e, b;
    li = $signed(l);
    al[0] = $signed(a1); al[1] = $signed(a2); al[2] = $signed(a3);
    t = 2 * li + al[0] + al[1] + al[2];
    r.betas = '0; r.sat = '0; r.age = 0;
    for (int i = 0; i < 3; i++) begin
      e = t - al[i];
      b = (e >= 0) ? e / 2 : -((1 - e) / 2);
      if (b > 31)  begin b = 31;  r.sat[i] = 1'b1; end
      if (b < -32) begin b = -32; r.sat[i] = 1'b1; end
      r.betas[17 - 6*i -: 6] = 6'(b);
    end
    r.dec = (t < 0);
    return r;
  endfunction

  function automatic bit model_valid();
    return (q.size() > 0) && (q[0].age >= 1);
  endfunction

  // Model update: pipeline of capacity two, head becomes visible one edge after entry.
  always @(posedge clk) begin
    bit mir, mv;
    ent_t e;
    if (!rst_n) begin
      q.delete();
    end else begin
      mir = !(q.size() == 2 && !bus.out_ready);
      mv  = model_valid();
      if (mv && bus.out_ready) void'(q.pop_front());
      foreach (q[i]) q[i].age++;
      if (bus.in_valid && mir) begin
        e = model(bus.llr, bus.alpha1, bus.alpha2, bus.alpha3);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", int'(bus.in_ready), int'(!(q.size() == 2 && !bus.out_ready)));
      chk("out_valid", int'(bus.out_valid), int'(model_valid()));
      if (model_valid() && bus.out_valid) begin
        chk("betas", int'({bus.beta1, bus.beta2, bus.beta3}), int'(q[0].betas));
        chk("beta_sat", int'(bus.beta_sat), int'(q[0].sat));
        chk("decision", int'(bus.decision), int'(q[0].dec));
      end
    end
  end

  task automatic drive(input logic [5:0] l, input logic [5:0] a1,
                       input logic [5:0] a2, input logic [5:0] a3);
    bus.llr = l; bus.alpha1 = a1; bus.alpha2 = a2; bus.alpha3 = a3;
  endtask

  task automatic send(input logic [5:0] l, input logic [5:0] a1,
                      input logic [5:0] a2, input logic [5:0] a3);
    bit acc = 1'b0;
    drive(l, a1, a2, a3);
    bus.in_valid = 1'b1;
    for (int k = 0; k < 20 && !acc; k++) begin
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic run_vec(input string nm, input logic [5:0] l, input logic [5:0] a1,
                         input logic [5:0] a2, input logic [5:0] a3,
                         input logic [17:0] eb, input logic [2:0] es, input logic ed);
    bit got = 1'b0;
    send(l, a1, a2, a3);
    bus.in_valid = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); got = bus.out_valid;
      if (!got) begin @(posedge clk); #1; end
    end
    chk({nm, "_valid"}, int'(got), 1);
    chk({nm, "_betas"}, int'({bus.beta1, bus.beta2, bus.beta3}), int'(eb));
    chk({nm, "_sat"}, int'(bus.beta_sat), int'(es));
    chk({nm, "_dec"}, int'(bus.decision), int'(ed));
    @(posedge clk); #1;
  endtask

  logic [5:0] sv_l[6] = '{6'h08, 6'h1F, 6'h20, 6'h03, 6'h3A, 6'h11};
  logic [5:0] sv_a[6] = '{6'h10, 6'h1F, 6'h20, 6'h3F, 6'h05, 6'h2C};
  bit         pat[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int idx;
    bit acc;
    rst_n = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    drive(6'h0, 6'h0, 6'h0, 6'h0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_betas", int'({bus.beta1, bus.beta2, bus.beta3}), 0);
    chk("rst_sat", int'(bus.beta_sat), 0);
    chk("rst_dec", int'(bus.decision), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_vec("nominal", 6'h08, 6'h10, 6'h10, 6'h10, {6'h18, 6'h18, 6'h18}, 3'b000, 1'b0);
    run_vec("possat",  6'h1F, 6'h1F, 6'h1F, 6'h1F, {6'h1F, 6'h1F, 6'h1F}, 3'b111, 1'b0);
    run_vec("negsat",  6'h20, 6'h20, 6'h20, 6'h20, {6'h20, 6'h20, 6'h20}, 3'b111, 1'b1);
    run_vec("floorp",  6'h00, 6'h01, 6'h00, 6'h00, {6'h00, 6'h00, 6'h00}, 3'b000, 1'b0);
    run_vec("floorn",  6'h00, 6'h3F, 6'h00, 6'h00, {6'h00, 6'h3F, 6'h3F}, 3'b000, 1'b1);

    // Back-to-back stream under a toggling downstream ready.
    idx = 0;
    for (int c = 0; c < 60 && (idx < 6 || c < 6); c++) begin
      bus.out_ready = (c < 6) ? pat[c] : 1'b1;
      bus.in_valid  = (idx < 6);
      if (idx < 6) drive(sv_l[idx], sv_a[idx], sv_a[(idx+1)%6], sv_a[(idx+2)%6]);
      @(negedge clk); acc = bus.in_ready;
      @(posedge clk); #1;
      if (acc && idx < 6) idx++;
    end
    chk("stream_sent", idx, 6);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("stream_drained", q.size(), 0);

    // Reset with two vectors in flight: neither may come out.
    bus.out_ready = 1'b0;
    send(6'h05, 6'h01, 6'h02, 6'h03);
    send(6'h3B, 6'h07, 6'h38, 6'h0C);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("full_in_ready", int'(bus.in_ready), 0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_betas", int'({bus.beta1, bus.beta2, bus.beta3}), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1; bus.out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_out_valid", int'(bus.out_valid), 0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/variable_node.md
# variable_node

Degree-3 min-sum variable node processing unit for the LDPC decoder. It is the counterpart of the check node: it takes the channel LLR and three check-to-variable messages (alpha, 2.4 two's complement) and returns three variable-to-check messages (beta, 3.3 two's complement) plus a hard decision. Transfers into and out of the two-stage registered pipeline use valid/ready handshakes, so the block can sit between alpha memories and the check-node array while either side stalls.

## Interface
- No parameters. Degree (3) and formats (alpha 2.4, beta/LLR 3.3, all 6-bit) are fixed.
- clk  input  1  single clock; one clock; reset is synchronous and active-low
- rst_n  input  1  synchronous active-low reset, sampled on rising clk
- in_valid  input  1  llr/alpha1..3 valid this cycle
- in_ready  output  1  block accepts input this cycle
- llr  input  6  channel LLR, 3.3 two's complement
- alpha1, alpha2, alpha3  input  6 each  check-to-variable messages, 2.4 two's complement
- out_valid  output  1  beta/decision valid
- out_ready  input  1  downstream accepts output
- beta1, beta2, beta3  output  6 each  variable-to-check messages, 3.3 two's complement, saturated
- beta_sat  output  3  bit i-1 set when beta_i was clipped
- decision  output  1  hard bit: 1 when total LLR < 0, else 0

## Operation
- All arithmetic uses signed 9-bit values in 1/16 units (4 fractional bits).
- llr is sign-extended and shifted left by 1. Alphas are sign-extended.
- total = (llr<<1) + alpha1 + alpha2 + alpha3. Range −160..155, so 9 bits is sufficient and there is no internal overflow.
- ext_i = total − alpha_i, range −128..124.
- beta_i = ext_i arithmetic-shifted right by 1 (floor, no rounding), then saturated to [−32, 31]. Clipping sets beta_sat[i-1].
- decision = total[8] (sign bit).
- Stage 1 (S1) registers total, the three alphas and valid v1.
- Stage 2 (S2) registers beta1..3, beta_sat, decision and valid v2.
- Enables:
  - en2 = !v2 || out_ready
  - en1 = !v1 || en2
  - in_ready = en1 (combinational from v1, v2, out_ready; no dependence on in_valid)
- Input transfer: in_valid && in_ready. On en1: v1 <= in_valid and S1 data loads. S1 data may load unconditionally on en1.
- On en2: v2 <= v1 and S2 data loads from S1.
- out_valid = v2. Output data is held stable while out_valid && !out_ready.
- No bubbles: with out_ready held high, one vector is accepted and one emitted every cycle.
- No skid buffer is needed. in_ready already reflects downstream stall through the enable chain.

## Timing
- Reset (rst_n low at clk edge):
  - v1 = v2 = 0, so out_valid = 0.
  - beta1..3 = 6'h00, beta_sat = 3'b000, decision = 0.
  - S1 data registers clear to 0.
- in_ready is 1 in the first cycle after reset. Reset overrides all handshake activity. In-flight vectors are discarded, not emitted.
- Latency: a vector accepted at edge N appears with out_valid = 1 after edge N+1, i.e. visible in cycle N+1 → N+2 when unstalled.
- Throughput: 1 vector/cycle.
- Capacity: 2 vectors. When both stages are full and out_ready = 0, in_ready = 0.
- Simultaneous accept and emit in the same cycle is legal. Both stages advance.
- When out_ready drops: in_ready drops in the same cycle only if v1 && v2. An empty S1 still absorbs one more vector.
- in_valid low while in_ready is high inserts a bubble (v1 <= 0). Nothing is emitted for it.

## Test plan
- Nominal: llr=6'h08, alphas 6'h10,6'h10,6'h10 → 2 cycles later beta1..3=6'h18, beta_sat=0, decision=0.
- Positive saturation: llr=6'h1F, alphas 6'h1F ×3 → betas=6'h1F, beta_sat=3'b111, decision=0.
- Negative saturation: llr=6'h20, alphas 6'h20 ×3 → betas=6'h20, beta_sat=3'b111, decision=1.
- Floor truncation:
  - llr=0, alphas 6'h01,0,0 → beta1=6'h00, beta2=beta3=6'h00, decision=0.
  - llr=0, alphas 6'h3F,0,0 → beta1=6'h00, beta2=beta3=6'h3F, decision=1.
- Backpressure: stream 6 vectors back-to-back with out_ready toggling 1,0,0,1,1,0 →
  - in_ready=0 exactly when both stages are full;
  - outputs arrive in order, none lost or duplicated;
  - output data is held while stalled.
- Reset mid-operation: 2 vectors in flight, rst_n=0 for one edge → out_valid=0, betas=0, in_ready=1 the next cycle, and neither vector is ever emitted.
